// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multicycle HI/LO multiply/divide unit with fixed latencies.
//               Optional MADD (op 7) enabled by defining MULDIV_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic       c_st_idle  = 1'b0;
  localparam logic       c_st_busy  = 1'b1;
  localparam logic [2:0] c_op_mult  = 3'd1;
  localparam logic [2:0] c_op_multu = 3'd2;
  localparam logic [2:0] c_op_div   = 3'd3;
  localparam logic [2:0] c_op_divu  = 3'd4;
  localparam logic [2:0] c_op_mthi  = 3'd5;
  localparam logic [2:0] c_op_mtlo  = 3'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] c_op_madd  = 3'd7;
`endif
  localparam logic [7:0] c_mul_lat  = 8'(MUL_LAT);
  localparam logic [7:0] c_div_lat  = 8'(DIV_LAT);

  logic             r_state;
  logic             w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_accept;
  logic             w_long_op;
  logic [7:0]       w_lat;
  logic             w_last;
  logic             w_commit;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  assign w_accept = start & ~req & (r_state == c_st_idle);
  assign w_last   = (r_cnt == 8'd1);

  always_comb begin
    w_long_op = 1'b0;
    w_lat     = c_mul_lat;
    case (op)
      c_op_mult, c_op_multu: w_long_op = 1'b1;
      c_op_div, c_op_divu: begin
        w_long_op = 1'b1;
        w_lat     = c_div_lat;
      end
`ifdef MULDIV_MADD_EN
      c_op_madd: w_long_op = 1'b1;
`endif
      default: w_long_op = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept && w_long_op) w_state_nxt = c_st_busy;
      c_st_busy: if (w_last)                w_state_nxt = c_st_idle;
      default:                              w_state_nxt = c_st_idle;
    endcase
  end

  // FSM: output logic (registered afterwards so busy/done come from flops)
  always_comb begin
    w_commit   = (r_state == c_st_busy) && w_last;
    w_busy_nxt = (w_state_nxt == c_st_busy);
    w_done_nxt = w_commit;
    w_cnt_nxt  = r_cnt;
    if (w_accept && w_long_op)      w_cnt_nxt = w_lat;
    else if (r_state == c_st_busy)  w_cnt_nxt = r_cnt - 8'd1;
  end

  // Arithmetic on captured operands; evaluated for the commit edge only.
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_div_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_dvd;
  logic [WIDTH-1:0]   w_dvs;
  logic [WIDTH-1:0]   w_q_u;
  logic [WIDTH-1:0]   w_r_u;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Signed divide via magnitudes; -2^(W-1)/-1 falls out as lo=-2^(W-1), hi=0.
  assign w_div_signed = (r_op == c_op_div);
  assign w_neg_a      = w_div_signed & r_a[WIDTH-1];
  assign w_neg_b      = w_div_signed & r_b[WIDTH-1];
  assign w_dvd        = w_neg_a ? -r_a : r_a;
  assign w_dvs        = w_neg_b ? -r_b : r_b;
  assign w_q_u        = w_dvd / w_dvs;
  assign w_r_u        = w_dvd % w_dvs;
  assign w_quo        = (w_neg_a ^ w_neg_b) ? -w_q_u : w_q_u;
  assign w_rem        = w_neg_a ? -w_r_u : w_r_u;

  logic               w_res_wr;
  logic [2*WIDTH-1:0] w_res;

  always_comb begin
    w_res_wr = 1'b0;
    w_res    = {r_hi, r_lo};
    case (r_op)
      c_op_mult: begin
        w_res_wr = 1'b1;
        w_res    = w_prod_s;
      end
      c_op_multu: begin
        w_res_wr = 1'b1;
        w_res    = w_prod_u;
      end
      c_op_div, c_op_divu: begin
        w_res_wr = (r_b != '0);
        w_res    = {w_rem, w_quo};
      end
`ifdef MULDIV_MADD_EN
      c_op_madd: begin
        w_res_wr = 1'b1;
        w_res    = {r_hi, r_lo} + w_prod_s;
      end
`endif
      default: w_res_wr = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= 8'd0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_op   <= 3'd0;
      r_a    <= '0;
      r_b    <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_accept && w_long_op) begin
        r_op <= op;
        r_a  <= rs_data;
        r_b  <= rt_data;
      end
      if (w_commit) begin
        if (w_res_wr) begin
          r_hi <= w_res[2*WIDTH-1:WIDTH];
          r_lo <= w_res[WIDTH-1:0];
        end
      end else if (w_accept && op == c_op_mthi) begin
        r_hi <= rs_data;
      end else if (w_accept && op == c_op_mtlo) begin
        r_lo <= rs_data;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        req = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int dones_seen = 0;
  logic [63:0] exp_q[$];

  muldiv_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .req(req),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request for one accepting edge; returns at the following negedge.
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    start = 1'b1; op = o; rs_data = a; rt_data = b; req = rq;
    @(negedge clk);
    start = 1'b0; req = 1'b0; op = 3'd0;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    @(negedge clk);
    drive(o, a, b, rq);
  endtask

  task automatic count_busy(input string name, input int exp_len);
    int n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(exp_len));
  endtask

  // Monitor: every done pulse retires one expected {hi,lo}.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", {hi, lo}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          e = exp_q.pop_front();
          check("result_hilo", {hi, lo}, e);
          check("busy_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    int n;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    // MULT -2*3
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA}); pushes++;
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_hold_hilo", {hi, lo}, 64'd0);
    count_busy("mult_busy_len", 5);

    // MULTU
    exp_q.push_back({32'h0000_0002, 32'hFFFF_FFFA}); pushes++;
    issue(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy("multu_busy_len", 5);

    // DIV -7/2
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD}); pushes++;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy("div_busy_len", 10);

    // DIVU 7/0: full latency, hi/lo unchanged
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD}); pushes++;
    issue(3'd4, 32'd7, 32'd0, 1'b0);
    count_busy("divu0_busy_len", 10);

    // req suppresses acceptance
    issue(3'd1, 32'd9, 32'd9, 1'b1);
    check("req_mult_busy", 64'(busy), 64'd0);
    issue(3'd5, 32'h1234, 32'd0, 1'b1);
    check("req_mthi_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(3'd5, 32'h1234, 32'd0, 1'b0);
    check("mthi_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFD});
    check("mthi_busy", 64'(busy), 64'd0);

    // DIV 100/7 with a MULT start arriving mid-operation
    exp_q.push_back({32'd2, 32'd14}); pushes++;
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (n == 3) begin start = 1'b1; op = 3'd1; rs_data = 32'd5; rt_data = 32'd5; end
      else begin start = 1'b0; op = 3'd0; end
      @(negedge clk);
    end
    start = 1'b0;
    check("div_ignore_busy_len", 64'(n), 64'd10);
    repeat (3) @(negedge clk);
    check("no_queued_start", 64'(busy), 64'd0);

    // Signed overflow case
    exp_q.push_back({32'h0000_0000, 32'h8000_0000}); pushes++;
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy("div_ovf_busy_len", 10);

    // MADD (or NOP when the feature is absent)
    issue(3'd5, 32'd0, 32'd0, 1'b0);
    issue(3'd6, 32'd5, 32'd0, 1'b0);
    check("mtlo_hilo", {hi, lo}, {32'd0, 32'd5});
`ifdef MULDIV_MADD_EN
    exp_q.push_back({32'd0, 32'd11}); pushes++;
    issue(3'd7, 32'd2, 32'd3, 1'b0);
    count_busy("madd_busy_len", 5);
`else
    issue(3'd7, 32'd2, 32'd3, 1'b0);
    check("op7_nop_busy", 64'(busy), 64'd0);
    repeat (6) @(negedge clk);
    check("op7_nop_hilo", {hi, lo}, {32'd0, 32'd5});
`endif

    // Asynchronous reset in the middle of a DIV
    issue(3'd3, 32'd9, 32'd2, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop_rst_busy", 64'(busy), 64'd0);
    check("midop_rst_done", 64'(done), 64'd0);
    check("midop_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back({32'd0, 32'd12}); pushes++;
    drive(3'd2, 32'd3, 32'd4, 1'b0);
    count_busy("post_rst_busy_len", 5);

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(dones_seen), 64'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width (legal range >= 2).
REQ-002 SHALL have parameter MUL_LAT, default 5, multiply latency in cycles (legal range 1..255).
REQ-003 SHALL have parameter DIV_LAT, default 10, divide latency in cycles (legal range 1..255).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  operation request, sampled each rising edge.
REQ-007 SHALL have port op  input  3  opcode: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
REQ-008 SHALL have port rs_data  input  WIDTH  operand A (dividend, or MTHI/MTLO source).
REQ-009 SHALL have port rt_data  input  WIDTH  operand B (divisor).
REQ-010 SHALL have port req  input  1  exception/interrupt flush; suppresses acceptance.
REQ-011 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-012 SHALL have port done  output  1  registered one-cycle pulse on result commit.
REQ-013 SHALL have port hi  output  WIDTH  HI register value.
REQ-014 SHALL have port lo  output  WIDTH  LO register value.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BUSY, plus a down-counter sized for 255.
REQ-016 SHALL accept an op only when start=1, req=0 and state=IDLE; otherwise it SHALL ignore start.
REQ-017 SHALL, on accepting ops 1-4 (or 7 when enabled), capture operands, load the counter with MUL_LAT (ops 1, 2, 7) or DIV_LAT (ops 3, 4), and enter BUSY.
REQ-018 SHALL, for an op accepted at edge t with latency L, keep busy=1 from edge t through edge t+L; at edge t+L it SHALL write hi/lo, set done=1 for one cycle, and return to IDLE.
REQ-019 SHALL hold hi/lo at their previous values while busy=1.
REQ-020 SHALL write MTHI/MTLO to hi/lo at the accepting edge, with no busy and no done.
REQ-021 SHALL treat NOP as no operation.
REQ-022 SHALL compute MULT as a signed 2*WIDTH product and MULTU as unsigned, placing the upper half in hi and the lower half in lo.
REQ-023 SHALL compute DIV as signed division truncated toward zero (quotient in lo, remainder in hi, remainder sign equal to dividend sign) and DIVU as unsigned division.
REQ-024 SHALL, on divide by zero, leave hi/lo unchanged while still completing the full DIV_LAT busy period with a done pulse.
REQ-025 SHALL, on signed -2^(WIDTH-1)/-1, produce lo=-2^(WIDTH-1) and hi=0.
REQ-026 SHALL NOT abort an operation already in BUSY when req is asserted.
REQ-027 SHALL NOT queue a start that arrives while busy=1.

Reset
REQ-028 SHALL, on reset=1, immediately and asynchronously force state=IDLE, counter=0, busy=0, done=0, hi=0 and lo=0, including in the middle of an operation.
REQ-029 SHALL accept a new op at the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, when macro MULDIV_MADD_EN is defined, implement op 7 MADD: {hi,lo} <= {hi,lo} + signed(rs_data)*signed(rt_data) mod 2^(2*WIDTH), with MUL_LAT latency.
REQ-031 SHALL, when MULDIV_MADD_EN is undefined, treat op 7 as NOP: no busy, no done, hi/lo unchanged.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-032 SHALL cover MULT rs=0xFFFFFFFE, rt=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once; MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-033 SHALL cover DIV rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> busy 10 cycles, done pulses, hi/lo unchanged.
REQ-034 SHALL cover start=1 with req=1 (MULT, then MTHI 0x1234) -> busy stays 0, hi/lo unchanged; MTHI 0x1234 with req=0 -> hi=0x1234 next cycle, busy stays 0.
REQ-035 SHALL cover a second MULT start during a DIV -> ignored, with the DIV result committed at cycle 10; reset asserted at DIV cycle 3 -> busy=0, done=0, hi=lo=0 immediately.
REQ-036 SHALL cover DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL cover, with MULDIV_MADD_EN defined, hi=0, lo=5, MADD rs=2, rt=3 -> lo=11, hi=0 after 5 cycles; with the macro undefined, the same stimulus -> busy stays 0, lo=5.
